// File: rtl/mips_datapath_units.sv
// Storage and compute primitives for the pipelined MIPS core: a 32x32 register file,
// a one-cycle ALU with predecoded control, and a synchronous single-port word memory.
module mips_datapath_units #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_WORD  = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    // register file
    input  logic [4:0]           gpr_rs,
    input  logic [4:0]           gpr_rt,
    output logic [31:0]          gpr_rrs,
    output logic [31:0]          gpr_rrt,
    input  logic [4:0]           gpr_rd,
    input  logic [31:0]          gpr_rrd,
    input  logic                 gpr_we,
    // alu
    input  logic [5:0]           alu_opcode_fwd,
    input  logic [5:0]           alu_funct_fwd,
    input  logic [5:0]           alu_opcode,
    input  logic [5:0]           alu_funct,
    input  logic [31:0]          alu_rrs,
    input  logic [31:0]          alu_rrt_in,
    input  logic [15:0]          alu_imm,
    input  logic [4:0]           alu_shamt_in,
    output logic [31:0]          alu_rslt,
    // memory
    input  logic [31:0]          mem_addr,
    input  logic [MEM_WIDTH-1:0] mem_in,
    input  logic                 mem_we,
    output logic [MEM_WIDTH-1:0] mem_out
);

    localparam int ADDR_W = $clog2(MEM_WORD);

    typedef enum logic [4:0] {
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV,
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_ZERO,
        ALU_ADDI, ALU_SLTI, ALU_SLTIU, ALU_ANDI, ALU_ORI, ALU_XORI, ALU_LUI
    } alu_op_e;

    // ---------------- register file ----------------
    logic [31:0] regs [32];

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (gpr_we && gpr_rd != 5'd0) begin
            regs[gpr_rd] <= gpr_rrd;
        end
    end

    // Write-through bypass lets a producer and consumer share the same cycle.
    always_comb begin
        gpr_rrs = regs[gpr_rs];
        gpr_rrt = regs[gpr_rt];
        if (gpr_rs == 5'd0)                          gpr_rrs = '0;
        else if (gpr_we && !rst && gpr_rd == gpr_rs) gpr_rrs = gpr_rrd;
        if (gpr_rt == 5'd0)                          gpr_rrt = '0;
        else if (gpr_we && !rst && gpr_rd == gpr_rt) gpr_rrt = gpr_rrd;
    end

    // ---------------- alu predecode ----------------
    alu_op_e op_fwd;
    alu_op_e op_cur;

    // NOTE: a default is assigned before the case so no path leaves op_fwd unassigned (no latch).
    always_comb begin
        op_fwd = ALU_ADDI;
        if (alu_opcode_fwd == 6'd0) begin
            case (alu_funct_fwd)
                6'd0:         op_fwd = ALU_SLL;
                6'd2:         op_fwd = ALU_SRL;
                6'd3:         op_fwd = ALU_SRA;
                6'd4:         op_fwd = ALU_SLLV;
                6'd6:         op_fwd = ALU_SRLV;
                6'd7:         op_fwd = ALU_SRAV;
                6'd32, 6'd33: op_fwd = ALU_ADD;
                6'd34, 6'd35: op_fwd = ALU_SUB;
                6'd36:        op_fwd = ALU_AND;
                6'd37:        op_fwd = ALU_OR;
                6'd38:        op_fwd = ALU_XOR;
                6'd39:        op_fwd = ALU_NOR;
                6'd42:        op_fwd = ALU_SLT;
                6'd43:        op_fwd = ALU_SLTU;
                default:      op_fwd = ALU_ZERO;
            endcase
        end else begin
            case (alu_opcode_fwd)
                6'd10:   op_fwd = ALU_SLTI;
                6'd11:   op_fwd = ALU_SLTIU;
                6'd12:   op_fwd = ALU_ANDI;
                6'd13:   op_fwd = ALU_ORI;
                6'd14:   op_fwd = ALU_XORI;
                6'd15:   op_fwd = ALU_LUI;
                default: op_fwd = ALU_ADDI;  // ADDI/ADDIU, LW/SW, branches, unknown
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) op_cur <= ALU_SLL;
        else     op_cur <= op_fwd;
    end

    // ---------------- alu datapath ----------------
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] alu_next;

    assign imm_sext = {{16{alu_imm[15]}}, alu_imm};
    assign imm_zext = {16'd0, alu_imm};

    always_comb begin
        alu_next = '0;
        case (op_cur)
            ALU_SLL:   alu_next = alu_rrt_in << alu_shamt_in;
            ALU_SRL:   alu_next = alu_rrt_in >> alu_shamt_in;
            ALU_SRA:   alu_next = $signed(alu_rrt_in) >>> alu_shamt_in;
            ALU_SLLV:  alu_next = alu_rrt_in << alu_rrs[4:0];
            ALU_SRLV:  alu_next = alu_rrt_in >> alu_rrs[4:0];
            ALU_SRAV:  alu_next = $signed(alu_rrt_in) >>> alu_rrs[4:0];
            ALU_ADD:   alu_next = alu_rrs + alu_rrt_in;
            ALU_SUB:   alu_next = alu_rrs - alu_rrt_in;
            ALU_AND:   alu_next = alu_rrs & alu_rrt_in;
            ALU_OR:    alu_next = alu_rrs | alu_rrt_in;
            ALU_XOR:   alu_next = alu_rrs ^ alu_rrt_in;
            ALU_NOR:   alu_next = ~(alu_rrs | alu_rrt_in);
            ALU_SLT:   alu_next = {31'd0, $signed(alu_rrs) < $signed(alu_rrt_in)};
            ALU_SLTU:  alu_next = {31'd0, alu_rrs < alu_rrt_in};
            ALU_ZERO:  alu_next = '0;
            ALU_ADDI:  alu_next = alu_rrs + imm_sext;
            ALU_SLTI:  alu_next = {31'd0, $signed(alu_rrs) < $signed(imm_sext)};
            ALU_SLTIU: alu_next = {31'd0, alu_rrs < imm_sext};
            ALU_ANDI:  alu_next = alu_rrs & imm_zext;
            ALU_ORI:   alu_next = alu_rrs | imm_zext;
            ALU_XORI:  alu_next = alu_rrs ^ imm_zext;
            ALU_LUI:   alu_next = {alu_imm, 16'd0};
            default:   alu_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) alu_rslt <= '0;
        else     alu_rslt <= alu_next;
    end

    // ---------------- word memory ----------------
    logic [MEM_WIDTH-1:0] mem_array [MEM_WORD];
    logic [ADDR_W-1:0]    mem_idx;

    assign mem_idx = mem_addr[ADDR_W-1:0];

    // NOTE: the array is deliberately not reset (contents survive rst); only the read register is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_out <= '0;
        end else begin
            mem_out <= mem_array[mem_idx];
            if (mem_we) mem_array[mem_idx] <= mem_in;
        end
    end

    // The datapath runs from predecoded control; the current-stage fields and high
    // address bits only travel alongside for the surrounding pipeline.
    logic unused_inputs;
    assign unused_inputs = ^{alu_opcode, alu_funct, mem_addr};

endmodule

// File: tb/tb_mips_datapath_units.sv
// Self-checking bench for mips_datapath_units: directed spec cases plus randomized
// traffic compared against a behavioural model of the register file, ALU and memory.
module tb_mips_datapath_units;

    localparam int MEM_WIDTH = 32;
    localparam int MEM_WORD  = 4096;

    logic                 clk;
    logic                 rst;
    logic [4:0]           gpr_rs, gpr_rt, gpr_rd;
    logic [31:0]          gpr_rrs, gpr_rrt, gpr_rrd;
    logic                 gpr_we;
    logic [5:0]           alu_opcode_fwd, alu_funct_fwd, alu_opcode, alu_funct;
    logic [31:0]          alu_rrs, alu_rrt_in, alu_rslt;
    logic [15:0]          alu_imm;
    logic [4:0]           alu_shamt_in;
    logic [31:0]          mem_addr;
    logic [MEM_WIDTH-1:0] mem_in, mem_out;
    logic                 mem_we;

    int checks = 0;
    int errors = 0;

    mips_datapath_units #(.MEM_WIDTH(MEM_WIDTH), .MEM_WORD(MEM_WORD)) dut (
        .clk(clk), .rst(rst),
        .gpr_rs(gpr_rs), .gpr_rt(gpr_rt), .gpr_rrs(gpr_rrs), .gpr_rrt(gpr_rrt),
        .gpr_rd(gpr_rd), .gpr_rrd(gpr_rrd), .gpr_we(gpr_we),
        .alu_opcode_fwd(alu_opcode_fwd), .alu_funct_fwd(alu_funct_fwd),
        .alu_opcode(alu_opcode), .alu_funct(alu_funct),
        .alu_rrs(alu_rrs), .alu_rrt_in(alu_rrt_in), .alu_imm(alu_imm),
        .alu_shamt_in(alu_shamt_in), .alu_rslt(alu_rslt),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_we(mem_we), .mem_out(mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [4:0]  sh;
    } alu_txn_t;

    alu_txn_t    alu_q[$];
    logic [31:0] alu_obs[$];
    logic [31:0] exp_q[$];
    logic [31:0] gpr_model [32];
    logic [31:0] mem_model [64];

    // Reference ALU written straight from the MIPS instruction semantics.
    function automatic logic [31:0] alu_ref(alu_txn_t t);
        logic [31:0] sx;
        logic [31:0] zx;
        sx = {{16{t.imm[15]}}, t.imm};
        zx = {16'd0, t.imm};
        if (t.op == 6'd0) begin
            case (t.fn)
                6'd0:  return t.rt << t.sh;
                6'd2:  return t.rt >> t.sh;
                6'd3:  return $signed(t.rt) >>> t.sh;
                6'd4:  return t.rt << t.rs[4:0];
                6'd6:  return t.rt >> t.rs[4:0];
                6'd7:  return $signed(t.rt) >>> t.rs[4:0];
                6'd32, 6'd33: return t.rs + t.rt;
                6'd34, 6'd35: return t.rs - t.rt;
                6'd36: return t.rs & t.rt;
                6'd37: return t.rs | t.rt;
                6'd38: return t.rs ^ t.rt;
                6'd39: return ~(t.rs | t.rt);
                6'd42: return ($signed(t.rs) < $signed(t.rt)) ? 32'd1 : 32'd0;
                6'd43: return (t.rs < t.rt) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
        end
        case (t.op)
            6'd10: return ($signed(t.rs) < $signed(sx)) ? 32'd1 : 32'd0;
            6'd11: return (t.rs < sx) ? 32'd1 : 32'd0;
            6'd12: return t.rs & zx;
            6'd13: return t.rs | zx;
            6'd14: return t.rs ^ zx;
            6'd15: return {t.imm, 16'd0};
            default: return t.rs + sx;
        endcase
    endfunction

    function automatic alu_txn_t mk(logic [5:0] op, logic [5:0] fn, logic [31:0] rs,
                                    logic [31:0] rt, logic [15:0] imm, logic [4:0] sh);
        alu_txn_t t;
        t.op = op; t.fn = fn; t.rs = rs; t.rt = rt; t.imm = imm; t.sh = sh;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Streams alu_q through the ALU with predecode leading by one cycle; records results.
    task automatic alu_run();
        int n;
        n = alu_q.size();
        alu_obs.delete();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                alu_opcode_fwd = alu_q[i].op;
                alu_funct_fwd  = alu_q[i].fn;
            end else begin
                alu_opcode_fwd = '0;
                alu_funct_fwd  = '0;
            end
            if (i > 0) begin
                alu_opcode   = alu_q[i-1].op;
                alu_funct    = alu_q[i-1].fn;
                alu_rrs      = alu_q[i-1].rs;
                alu_rrt_in   = alu_q[i-1].rt;
                alu_imm      = alu_q[i-1].imm;
                alu_shamt_in = alu_q[i-1].sh;
            end
            step();
            if (i > 0) alu_obs.push_back(alu_rslt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        gpr_rs = '0; gpr_rt = '0; gpr_rd = '0; gpr_rrd = '0; gpr_we = 1'b0;
        alu_opcode_fwd = '0; alu_funct_fwd = '0; alu_opcode = '0; alu_funct = '0;
        alu_rrs = '0; alu_rrt_in = '0; alu_imm = '0; alu_shamt_in = '0;
        mem_addr = '0; mem_in = '0; mem_we = 1'b0;
        for (int i = 0; i < 32; i++) gpr_model[i] = '0;
        repeat (2) step();
        checks++;
        if (alu_rslt !== 32'd0) begin
            errors++; $display("FAIL reset_alu_rslt got %h want 00000000", alu_rslt);
        end
        checks++;
        if (mem_out !== '0) begin
            errors++; $display("FAIL reset_mem_out got %h want 00000000", mem_out);
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            gpr_rs = 5'(i); gpr_rt = 5'(31 - i);
            #1;
            checks++;
            if (gpr_rrs !== 32'd0 || gpr_rrt !== 32'd0) begin
                errors++;
                $display("FAIL reset_gpr[%0d] got rrs=%h rrt=%h want 0", i, gpr_rrs, gpr_rrt);
            end
        end
        step();
    endtask

    task automatic test_gpr_directed();
        gpr_we = 1'b1; gpr_rd = 5'd5; gpr_rrd = 32'h1234_5678; gpr_rs = 5'd5; gpr_rt = 5'd0;
        #1;
        checks++;
        if (gpr_rrs !== 32'h1234_5678) begin
            errors++; $display("FAIL gpr_bypass_rs got %h want 12345678", gpr_rrs);
        end
        step();
        gpr_model[5] = 32'h1234_5678;
        gpr_we = 1'b0;
        #1;
        checks++;
        if (gpr_rrs !== 32'h1234_5678) begin
            errors++; $display("FAIL gpr_after_write got %h want 12345678", gpr_rrs);
        end
        gpr_we = 1'b1; gpr_rd = 5'd0; gpr_rrd = 32'hFFFF_FFFF; gpr_rs = 5'd0; gpr_rt = 5'd0;
        #1;
        checks++;
        if (gpr_rrs !== 32'd0 || gpr_rrt !== 32'd0) begin
            errors++; $display("FAIL gpr_r0_bypass got %h/%h want 0", gpr_rrs, gpr_rrt);
        end
        step();
        gpr_we = 1'b0;
        #1;
        checks++;
        if (gpr_rrs !== 32'd0) begin
            errors++; $display("FAIL gpr_r0_after got %h want 0", gpr_rrs);
        end
        gpr_we = 1'b1; gpr_rd = 5'd9; gpr_rrd = 32'hA5A5_F00F; gpr_rs = 5'd5; gpr_rt = 5'd9;
        #1;
        checks++;
        if (gpr_rrt !== 32'hA5A5_F00F || gpr_rrs !== 32'h1234_5678) begin
            errors++; $display("FAIL gpr_bypass_rt got %h/%h want 12345678/a5a5f00f", gpr_rrs, gpr_rrt);
        end
        step();
        gpr_model[9] = 32'hA5A5_F00F;
        gpr_we = 1'b0;
    endtask

    task automatic test_gpr_random();
        logic [31:0] exp_rs, exp_rt;
        for (int n = 0; n < 60; n++) begin
            gpr_rs  = 5'($urandom_range(0, 31));
            gpr_rt  = 5'($urandom_range(0, 31));
            gpr_rd  = (n % 4 == 0) ? gpr_rs : 5'($urandom_range(0, 31));
            gpr_we  = 1'($urandom_range(0, 1));
            gpr_rrd = $urandom;
            #1;
            exp_rs = (gpr_rs == 0) ? 32'd0 : (gpr_we && gpr_rd == gpr_rs) ? gpr_rrd : gpr_model[gpr_rs];
            exp_rt = (gpr_rt == 0) ? 32'd0 : (gpr_we && gpr_rd == gpr_rt) ? gpr_rrd : gpr_model[gpr_rt];
            checks++;
            if (gpr_rrs !== exp_rs || gpr_rrt !== exp_rt) begin
                errors++;
                $display("FAIL gpr_random[%0d] got %h/%h want %h/%h", n, gpr_rrs, gpr_rrt, exp_rs, exp_rt);
            end
            step();
            if (gpr_we && gpr_rd != 0) gpr_model[gpr_rd] = gpr_rrd;
        end
        gpr_we = 1'b0;
    endtask

    task automatic test_alu_directed();
        alu_q.delete(); exp_q.delete();
        alu_q.push_back(mk(6'd0,  6'd33, 32'd7,          32'hFFFF_FFFF, 16'h0,    5'd0)); exp_q.push_back(32'd6);
        alu_q.push_back(mk(6'd0,  6'd34, 32'd3,          32'd5,         16'h0,    5'd0)); exp_q.push_back(32'hFFFF_FFFE);
        alu_q.push_back(mk(6'd0,  6'd42, 32'hFFFF_FFFF,  32'd1,         16'h0,    5'd0)); exp_q.push_back(32'd1);
        alu_q.push_back(mk(6'd0,  6'd43, 32'hFFFF_FFFF,  32'd1,         16'h0,    5'd0)); exp_q.push_back(32'd0);
        alu_q.push_back(mk(6'd0,  6'd3,  32'd0,          32'h8000_0000, 16'h0,    5'd4)); exp_q.push_back(32'hF800_0000);
        alu_q.push_back(mk(6'd0,  6'd6,  32'd36,         32'h8000_0000, 16'h0,    5'd0)); exp_q.push_back(32'h0800_0000);
        alu_q.push_back(mk(6'd13, 6'd0,  32'd0,          32'd0,         16'h8000, 5'd0)); exp_q.push_back(32'h0000_8000);
        alu_q.push_back(mk(6'd9,  6'd0,  32'd1,          32'd0,         16'hFFFF, 5'd0)); exp_q.push_back(32'd0);
        alu_q.push_back(mk(6'd15, 6'd0,  32'd0,          32'd0,         16'h1234, 5'd0)); exp_q.push_back(32'h1234_0000);
        alu_q.push_back(mk(6'd0,  6'd39, 32'd0,          32'd0,         16'h0,    5'd0)); exp_q.push_back(32'hFFFF_FFFF);
        alu_q.push_back(mk(6'd10, 6'd0,  32'hFFFF_FFFE,  32'd0,         16'hFFFF, 5'd0)); exp_q.push_back(32'd1);
        alu_q.push_back(mk(6'd11, 6'd0,  32'd5,          32'd0,         16'hFFFF, 5'd0)); exp_q.push_back(32'd1);
        alu_q.push_back(mk(6'd0,  6'd8,  32'h1234,       32'h5678,      16'h0,    5'd0)); exp_q.push_back(32'd0);
        alu_q.push_back(mk(6'd4,  6'd0,  32'h10,         32'd0,         16'hFFFC, 5'd0)); exp_q.push_back(32'h0000_000C);
        alu_q.push_back(mk(6'd0,  6'd0,  32'd0,          32'd1,         16'h0,    5'd31)); exp_q.push_back(32'h8000_0000);
        alu_q.push_back(mk(6'd12, 6'd0,  32'hFFFF_FFFF,  32'd0,         16'h8001, 5'd0)); exp_q.push_back(32'h0000_8001);
        alu_run();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (alu_obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL alu_directed[%0d] op=%0d fn=%0d got %h want %h",
                         i, alu_q[i].op, alu_q[i].fn, alu_obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        alu_q.delete(); exp_q.delete();
        alu_q.push_back(mk(6'd0,  6'd33, 32'h100,  32'h23,   16'h0,    5'd0)); exp_q.push_back(32'h123);
        alu_q.push_back(mk(6'd0,  6'd36, 32'hF0F0, 32'h0FF0, 16'h0,    5'd0)); exp_q.push_back(32'h00F0);
        alu_q.push_back(mk(6'd35, 6'd0,  32'h1000, 32'd0,    16'hFFF8, 5'd0)); exp_q.push_back(32'h0FF8);
        alu_run();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (alu_obs[i] !== exp_q[i]) begin
                errors++; $display("FAIL alu_b2b[%0d] got %h want %h", i, alu_obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_alu_random();
        logic [5:0] op_tab [16] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd8, 6'd9, 6'd10, 6'd11,
                                    6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43, 6'd4, 6'd2};
        logic [5:0] fn_tab [20] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8, 6'd32, 6'd33, 6'd34,
                                    6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd1, 6'd13, 6'd63};
        logic [31:0] want;
        alu_q.delete();
        for (int i = 0; i < 60; i++) begin
            alu_q.push_back(mk(op_tab[$urandom_range(0, 15)], fn_tab[$urandom_range(0, 19)],
                               (i % 5 == 0) ? 32'h8000_0000 : $urandom, $urandom,
                               16'($urandom), 5'($urandom)));
        end
        alu_run();
        for (int i = 0; i < alu_q.size(); i++) begin
            want = alu_ref(alu_q[i]);
            checks++;
            if (alu_obs[i] !== want) begin
                errors++;
                $display("FAIL alu_random[%0d] op=%0d fn=%0d rs=%h rt=%h imm=%h sh=%0d got %h want %h",
                         i, alu_q[i].op, alu_q[i].fn, alu_q[i].rs, alu_q[i].rt, alu_q[i].imm,
                         alu_q[i].sh, alu_obs[i], want);
            end
        end
    endtask

    task automatic test_mem();
        mem_we = 1'b1; mem_addr = 32'd10; mem_in = 32'hDEAD_BEEF;
        step();
        mem_we = 1'b0;
        step();
        checks++;
        if (mem_out !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL mem_read_after_write got %h want deadbeef", mem_out);
        end
        mem_we = 1'b1; mem_in = 32'd1;
        step();
        checks++;
        if (mem_out !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL mem_rdw_old got %h want deadbeef", mem_out);
        end
        mem_we = 1'b0;
        step();
        checks++;
        if (mem_out !== 32'd1) begin
            errors++; $display("FAIL mem_rdw_new got %h want 00000001", mem_out);
        end
        mem_we = 1'b1; mem_addr = 32'(MEM_WORD + 10); mem_in = 32'hCAFE_0000;
        step();
        mem_we = 1'b0; mem_addr = 32'd10;
        step();
        checks++;
        if (mem_out !== 32'hCAFE_0000) begin
            errors++; $display("FAIL mem_alias got %h want cafe0000", mem_out);
        end
    endtask

    task automatic test_mem_random();
        logic [31:0] want;
        int          idx;
        for (int i = 0; i < 64; i++) begin
            mem_we = 1'b1; mem_addr = 32'(i); mem_in = $urandom; mem_model[i] = mem_in;
            step();
        end
        for (int n = 0; n < 80; n++) begin
            idx      = $urandom_range(0, 63);
            mem_addr = {8'($urandom), 12'd0, 12'(idx)};
            mem_we   = 1'($urandom_range(0, 1));
            mem_in   = $urandom;
            want     = mem_model[idx];
            step();
            if (mem_we) mem_model[idx] = mem_in;
            checks++;
            if (mem_out !== want) begin
                errors++; $display("FAIL mem_random[%0d] idx=%0d got %h want %h", n, idx, mem_out, want);
            end
        end
        mem_we = 1'b0;
    endtask

    task automatic test_async_reset();
        gpr_we = 1'b1; gpr_rd = 5'd3; gpr_rrd = 32'hAAAA_5555;
        mem_we = 1'b1; mem_addr = 32'd20; mem_in = 32'h1357_2468;
        alu_opcode_fwd = 6'd0; alu_funct_fwd = 6'd32;
        step();
        gpr_we = 1'b0; mem_we = 1'b0;
        alu_opcode = 6'd0; alu_funct = 6'd32; alu_rrs = 32'd5; alu_rrt_in = 32'd6;
        step();
        checks++;
        if (alu_rslt !== 32'd11 || mem_out !== 32'h1357_2468) begin
            errors++; $display("FAIL pre_reset got alu=%h mem=%h want 0000000b/13572468", alu_rslt, mem_out);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (alu_rslt !== 32'd0 || mem_out !== 32'd0) begin
            errors++; $display("FAIL async_reset_regs got alu=%h mem=%h want 0/0", alu_rslt, mem_out);
        end
        for (int i = 0; i < 32; i++) begin
            gpr_rs = 5'(i); gpr_rt = 5'(i);
            #1;
            checks++;
            if (gpr_rrs !== 32'd0 || gpr_rrt !== 32'd0) begin
                errors++; $display("FAIL async_reset_gpr[%0d] got %h/%h want 0", i, gpr_rrs, gpr_rrt);
            end
        end
        for (int i = 0; i < 32; i++) gpr_model[i] = '0;
        // writes presented while reset is held across an edge must be dropped
        mem_we = 1'b1; mem_addr = 32'd20; mem_in = 32'hFFFF_FFFF;
        gpr_we = 1'b1; gpr_rd = 5'd4; gpr_rrd = 32'h77; gpr_rs = 5'd4;
        alu_opcode_fwd = 6'd15;
        step();
        #1;
        checks++;
        if (gpr_rrs !== 32'd0) begin
            errors++; $display("FAIL gpr_write_in_reset got %h want 0", gpr_rrs);
        end
        @(negedge clk);
        rst = 1'b0; mem_we = 1'b0; gpr_we = 1'b0;
        alu_opcode = 6'd0; alu_funct = 6'd0; alu_rrt_in = 32'd1; alu_shamt_in = 5'd3; alu_rrs = 32'd0;
        step();
        checks++;
        if (alu_rslt !== 32'd8) begin
            errors++; $display("FAIL alu_ctrl_reset_sll got %h want 00000008", alu_rslt);
        end
        checks++;
        if (mem_out !== 32'h1357_2468) begin
            errors++; $display("FAIL mem_retained got %h want 13572468", mem_out);
        end
        gpr_rs = 5'd3; gpr_rt = 5'd4;
        #1;
        checks++;
        if (gpr_rrs !== 32'd0 || gpr_rrt !== 32'd0) begin
            errors++; $display("FAIL gpr_cleared got %h/%h want 0", gpr_rrs, gpr_rrt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_gpr_directed();
        test_gpr_random();
        test_alu_directed();
        test_back_to_back();
        test_alu_random();
        test_mem();
        test_mem_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
